lut4_arb: RTL and testbench

LUT4_ARB -- requirements
Module: lut4_arb

---
 rtl/lut4_arb_pkg.sv | 19 +
 rtl/lut4_eval.sv | 12 +
 rtl/lut4_arb.sv | 105 ++++++++++
 tb/tb_lut4_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut4_arb_pkg.sv
// rtl/lut4_arb_pkg.sv - shared constants and helpers for the LUT4 arbiter
package lut4_arb_pkg;

    localparam int LUT_W  = 16;
    localparam int LUT_IN = 4;
    localparam int CNT_W  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lut4_eval.sv
// rtl/lut4_eval.sv - combinational 4-input truth-table select
module lut4_eval
    import lut4_arb_pkg::*;
(
    input  logic [LUT_W-1:0]  init_i,
    input  logic [LUT_IN-1:0] in_i,
    output logic              z_o
);

    assign z_o = init_i[in_i];

endmodule

// File: rtl/lut4_arb.sv
// rtl/lut4_arb.sv - round-robin arbiter sharing one LUT4 evaluator, one-deep result slot
module lut4_arb
    import lut4_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [LUT_W*NREQ-1:0]   req_init_i,
    input  logic [LUT_IN*NREQ-1:0]  req_in_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_z_o,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [CNT_W-1:0]        grant_cnt_o
);

    logic             valid_q, valid_d;
    logic             z_q, z_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]   rot_w;
    logic              found_w;
    logic [IDW-1:0]    win_w;
    logic              slot_free_w;
    logic              xfer_w;
    logic [LUT_W-1:0]  sel_init_w;
    logic [LUT_IN-1:0] sel_in_w;
    logic              eval_z_w;

    // Rotate the doubled request vector so bit 0 is the requester at ptr.
    always_comb begin
        int pos;
        rot_w   = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
        found_w = 1'b0;
        pos     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_w[i]) begin
                found_w = 1'b1;
                pos     = int'(ptr_q) + i;
            end
        end
        if (pos >= NREQ) begin
            pos = pos - NREQ;
        end
        win_w = IDW'(pos);
    end

    assign slot_free_w = !valid_q || rsp_ready_i;
    assign xfer_w      = found_w && slot_free_w && !rst_i;
    assign req_ready_o = xfer_w ? (NREQ'(1) << win_w) : '0;

    assign sel_init_w = req_init_i[int'(win_w)*LUT_W +: LUT_W];
    assign sel_in_w   = req_in_i[int'(win_w)*LUT_IN +: LUT_IN];

    lut4_eval u_eval (
        .init_i (sel_init_w),
        .in_i   (sel_in_w),
        .z_o    (eval_z_w)
    );

    always_comb begin
        valid_d = valid_q;
        z_d     = z_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer_w) begin
            valid_d = 1'b1;
            z_d     = eval_z_w;
            id_d    = win_w;
            ptr_d   = (win_w == IDW'(NREQ - 1)) ? '0 : win_w + IDW'(1);
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (rsp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            z_q     <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            z_q     <= z_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_z_o     = z_q;
    assign rsp_id_o    = id_q;
    assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_lut4_arb.sv
// tb/tb_lut4_arb.sv - directed self-checking bench for lut4_arb
module tb_lut4_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_init;
    logic [15:0] req_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_z;
    logic [1:0]  rsp_id;
    logic [15:0] grant_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lut4_arb #(.NREQ(4), .IDW(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_init_i  (req_init),
        .req_in_i    (req_in),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_z_o     (rsp_z),
        .rsp_id_o    (rsp_id),
        .grant_cnt_o (grant_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [15:0] init, input logic [3:0] in);
        req_init[k*16 +: 16] = init;
        req_in[k*4 +: 4]     = in;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready_in_rst got=%b exp=0000", req_ready);
        end
        tick();
        req_valid = 4'h0;
        rst       = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        checks++;
        if (grant_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=0000", grant_cnt);
        end
    endtask

    task automatic test_single();
        set_req(0, 16'h8000, 4'hF);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        tick();
        set_req(0, 16'h8000, 4'hE);
        checks++;
        if ({rsp_valid, rsp_z, rsp_id} !== 4'b1100) begin
            failures++;
            $display("FAIL single_rsp_f got=%b%b%0d exp=v1 z1 id0", rsp_valid, rsp_z, rsp_id);
        end
        tick();
        req_valid = 4'h0;
        checks++;
        if ({rsp_valid, rsp_z, rsp_id} !== 4'b1000) begin
            failures++;
            $display("FAIL single_rsp_e got=%b%b%0d exp=v1 z0 id0", rsp_valid, rsp_z, rsp_id);
        end
        checks++;
        if (grant_cnt !== 16'd2) begin
            failures++;
            $display("FAIL single_cnt got=%0d exp=2", grant_cnt);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(k, (k % 2 == 1) ? 16'hFFFF : 16'h0000, 4'(k));
        end
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_ready = 4'b0001 << (i % 4);
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(i % 4) || rsp_z !== 1'(i % 2)) begin
                failures++;
                $display("FAIL rr_rsp[%0d] got=v%b id%0d z%b exp=v1 id%0d z%0d",
                         i, rsp_valid, rsp_id, rsp_z, i % 4, i % 2);
            end
            checks++;
            if (grant_cnt !== 16'(i + 1)) begin
                failures++;
                $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", i, grant_cnt, i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'h0) begin
                failures++;
                $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_z !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=v%b id%0d z%b exp=v1 id3 z1", i, rsp_valid, rsp_id, rsp_z);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = 4'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== 1'b1 || grant_cnt !== 16'd9) begin
            failures++;
            $display("FAIL bp_release_rsp got=v%b id%0d z%b cnt%0d exp=v1 id1 z1 cnt9",
                     rsp_valid, rsp_id, rsp_z, grant_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        rst       = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_z !== 1'b0 || grant_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset got=v%b id%0d z%b cnt%0d exp=all zero", rsp_valid, rsp_id, rsp_z, grant_cnt);
        end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_ptr_rsp got=v%b id%0d exp=v1 id0", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (65534) tick();
        checks++;
        if (grant_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload got=%h exp=fffe", grant_cnt);
        end
        tick();
        checks++;
        if (grant_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach got=%h exp=ffff", grant_cnt);
        end
        tick();
        tick();
        req_valid = 4'h0;
        checks++;
        if (grant_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=ffff", grant_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'h0;
        req_init  = '0;
        req_in    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
